fpu_op_dispatch: RTL and testbench
==================================

// Module: fpu_op_dispatch
// PURPOSE
//  Front end of the FPU: accepts operation requests (opcode, a, b) on a valid/ready port,
//  buffers them in-order in a small FIFO and steers each one to the selected arithmetic
//  unit (add/sub/mul/div) through per-unit valid/ready. Inverse of the result selector:
//  the result selector fans in by opcode; this block fans out by opcode. Each issue
//  carries a sequence tag so the back end can reorder or check completions.
// PARAMETERS
//  DEPTH   2   request FIFO entries (power of 2, >=2)
//  TAG_W   4   width of issue sequence tag
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  flush        in   1      synchronous abort: empties FIFO, drops presented request
//  in_valid     in   1      request valid
//  in_ready     out  1      FIFO can accept (= !full)
//  in_opcode    in   3      00 add, 01 sub, 10 mul, 11 div; opcode[2]=1 illegal
//  in_a, in_b   in   32     IEEE-754 single operands
//  unit_valid   out  4      one-hot issue strobe [0]add [1]sub [2]mul [3]div
//  unit_ready   in   4      per-unit accept
//  op_a, op_b   out  32     shared operand buses to all units
//  op_tag       out  TAG_W  sequence tag of presented request
//  err_illegal  out  1      1-cycle pulse when an illegal opcode is discarded
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, unit_valid=0, op_a=op_b=0, op_tag=0, tag counter=0,
//   err_illegal=0, in_ready=1 (0 while rst asserted). Reset mid-transfer drops everything.
//  Accept: in_valid&&in_ready at edge -> push {opcode,a,b}. No pass-through when full.
//  FSM: IDLE (FIFO empty, unit_valid=0) -> PRESENT when FIFO non-empty.
//   PRESENT: head drives op_a/op_b/op_tag, unit_valid=onehot(head opcode[1:0]).
//   Handshake done when unit_valid[i]&&unit_ready[i] -> pop, tag++ (wraps 2^TAG_W-1 -> 0);
//   stay PRESENT if entries remain, else IDLE. ready of non-selected units ignored.
//  Latency: request pushed into empty FIFO presented on next cycle; 1 issue/cycle max.
//  Stability: while unit_valid!=0 and not accepted, op_a/op_b/op_tag/unit_valid hold.
//  Illegal opcode at head: not presented (unit_valid=0), popped in one cycle,
//   err_illegal pulses next cycle, tag NOT incremented.
//  Simultaneous push+pop: allowed when not full; count unchanged.
//  Full: in_ready=0; push ignored even if pop in same cycle.
//  flush: highest priority; next cycle FIFO empty, IDLE, unit_valid=0; a handshake in the
//   flush cycle still counts (tag++); a push in the flush cycle is dropped. Tag not reset.
//  op_a/op_b/op_tag hold last presented value in IDLE.
// CONFIGURATION
//  FPU_DISPATCH_STATS_EN defined: adds outputs stat_issued[4][16] (per-unit issue counters,
//   saturating at 16'hFFFF) and stat_illegal[16]; cleared by rst only, not by flush.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package fpu_pkg: opcode localparams OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010,
//   OP_DIV=3'b011; FPU_W=32; FIFO entry layout {opcode,a,b} width 67.
//  One sub-module: fpu_req_fifo (sync FIFO, DEPTH x 67, push/pop/flush/full/empty).
//  Dispatch FSM, one-hot decode, tag counter and stats in this module.
// TESTING
//  1 add a=3F800000 b=40000000, unit_ready=4'b0001 -> unit_valid=0001 next cycle, tag 0.
//  2 mul request with unit_ready[2]=0 for 5 cycles -> unit_valid=0100, op_a/op_b/tag held 5 cycles.
//  3 push 3 back-to-back (DEPTH=2), all units stalled -> in_ready=0 after 2nd; 3rd retried.
//  4 opcode 3'b101 between sub and div -> err_illegal 1 pulse; sub tag 0, div tag 1.
//  5 18 issues with all ready -> op_tag wraps 15 -> 0 -> 1.
//  6 flush while div presented and 2 queued -> unit_valid=0 next cycle, in_ready=1, IDLE.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode encodings, operand width, request entry layout
// {opcode, a, b} and the opcode-to-unit one-hot decode.
package fpu_pkg;

    localparam int FPU_W   = 32;
    localparam int ENTRY_W = 3 + 2 * FPU_W;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [FPU_W-1:0] a;
        logic [FPU_W-1:0] b;
    } fpu_req_t;

    // Unit select: [0]add [1]sub [2]mul [3]div; anything with opcode[2] set selects nothing.
    function automatic logic [3:0] unit_onehot(input logic [2:0] opcode);
        case (opcode)
            OP_ADD:  unit_onehot = 4'b0001;
            OP_SUB:  unit_onehot = 4'b0010;
            OP_MUL:  unit_onehot = 4'b0100;
            OP_DIV:  unit_onehot = 4'b1000;
            default: unit_onehot = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// In-order request buffer for the FPU dispatcher. Synchronous FIFO of
// DEPTH entries (power of 2); flush empties it, push is refused when full
// even if a pop happens in the same cycle.
module fpu_req_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  fpu_req_t din,
    output fpu_req_t dout,
    output logic     full,
    output logic     empty,
    output logic     one
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign one     = (count == CW'(1));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fpu_op_dispatch.sv
// FPU front end: buffers requests in order and fans each one out to the
// add/sub/mul/div unit named by its opcode, tagging every issue with a
// wrapping sequence number. Illegal opcodes are dropped with a one-cycle
// err_illegal pulse and consume no tag.
// Optional: define FPU_DISPATCH_STATS_EN to add per-unit issue counters and
// an illegal-opcode counter (saturating, cleared only by rst).
module fpu_op_dispatch
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [FPU_W-1:0] in_a,
    input  logic [FPU_W-1:0] in_b,
    output logic [3:0]       unit_valid,
    input  logic [3:0]       unit_ready,
    output logic [FPU_W-1:0] op_a,
    output logic [FPU_W-1:0] op_b,
    output logic [TAG_W-1:0] op_tag,
    output logic             err_illegal
`ifdef FPU_DISPATCH_STATS_EN
    ,
    output logic [3:0][15:0] stat_issued,
    output logic [15:0]      stat_illegal
`endif
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t           state;
    fpu_req_t         req;
    fpu_req_t         head;
    logic             full;
    logic             empty;
    logic             one;
    logic             push;
    logic             pop;
    logic             presenting;
    logic             head_illegal;
    logic             fire;
    logic [TAG_W-1:0] tag;
    logic [FPU_W-1:0] last_a;
    logic [FPU_W-1:0] last_b;
    logic [TAG_W-1:0] last_tag;

    assign req      = {in_opcode, in_a, in_b};
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready && !flush;

    fpu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (req),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .one   (one)
    );

    // PRESENT always coincides with a non-empty FIFO, so the head is valid there.
    assign head_illegal = (state == PRESENT) && head.opcode[2];
    assign presenting   = (state == PRESENT) && !head.opcode[2];
    assign unit_valid   = presenting ? unit_onehot(head.opcode) : 4'b0000;
    assign fire         = |(unit_valid & unit_ready);
    assign pop          = fire || head_illegal;

    // Outside a presentation the operand buses keep the last presented request.
    assign op_a   = presenting ? head.a : last_a;
    assign op_b   = presenting ? head.b : last_b;
    assign op_tag = presenting ? tag    : last_tag;

    // Dispatch FSM: IDLE while empty, PRESENT while entries remain; flush forces IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (push) state <= PRESENT;
                PRESENT: if (pop && one && !push) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag counter, held presentation values and the illegal-drop pulse.
    // A handshake in a flush cycle still completed, so it still advances the tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag         <= '0;
            last_a      <= '0;
            last_b      <= '0;
            last_tag    <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= head_illegal;
            if (fire) tag <= tag + 1'b1;
            if (presenting) begin
                last_a   <= head.a;
                last_b   <= head.b;
                last_tag <= tag;
            end
        end
    end

`ifdef FPU_DISPATCH_STATS_EN
    // Saturating activity counters; flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
        end else begin
            for (int u = 0; u < 4; u++) begin
                if (unit_valid[u] && unit_ready[u] && stat_issued[u] != 16'hFFFF)
                    stat_issued[u] <= stat_issued[u] + 16'd1;
            end
            if (head_illegal && stat_illegal != 16'hFFFF)
                stat_illegal <= stat_illegal + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// Bench for fpu_op_dispatch: a queue-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_fpu_op_dispatch;
    import fpu_pkg::*;

    localparam int DEPTH = 2;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_opcode = '0;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic [3:0]       unit_valid;
    logic [3:0]       unit_ready = '0;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [TAG_W-1:0] op_tag;
    logic             err_illegal;
`ifdef FPU_DISPATCH_STATS_EN
    logic [3:0][15:0] stat_issued;
    logic [15:0]      stat_illegal;
`endif

    fpu_op_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .unit_valid  (unit_valid),
        .unit_ready  (unit_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_tag      (op_tag),
        .err_illegal (err_illegal)
`ifdef FPU_DISPATCH_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_illegal(stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Model state: pending requests in order, next tag, last presented values.
    fpu_req_t q[$];
    int          m_tag;
    logic [31:0] m_la, m_lb;
    int          m_ltag;
    bit          m_err;

    // Compare on the falling edge, then advance the model across the next rising edge.
    always @(negedge clk) begin : cmp
        bit          pres, ill, fire, pushed;
        logic [3:0]  uv;
        fpu_req_t    h;
        logic [31:0] ea, eb;
        int          et;
        if (rst) begin
            q.delete();
            m_tag = 0; m_la = '0; m_lb = '0; m_ltag = 0; m_err = 0;
            chk("rst_in_ready", 32'(in_ready), 'h0);
        end else begin
            pres = 0; ill = 0; uv = '0;
            ea = m_la; eb = m_lb; et = m_ltag;
            if (q.size() > 0) begin
                h = q[0];
                if (h.opcode[2]) ill = 1;
                else begin
                    pres = 1;
                    uv = 4'b0001 << h.opcode[1:0];
                    ea = h.a; eb = h.b; et = m_tag;
                end
            end
            chk("unit_valid", 32'(unit_valid), 32'(uv));
            chk("op_a", op_a, ea);
            chk("op_b", op_b, eb);
            chk("op_tag", 32'(op_tag), 32'(et));
            chk("in_ready", 32'(in_ready), (q.size() < DEPTH) ? 'h1 : 'h0);
            chk("err_illegal", 32'(err_illegal), 32'(m_err));
            fire   = pres && ((uv & unit_ready) != 4'b0000);
            pushed = in_valid && (q.size() < DEPTH) && !flush;
            m_err  = ill;
            if (pres) begin m_la = ea; m_lb = eb; m_ltag = et; end
            if (fire) m_tag = (m_tag + 1) % (1 << TAG_W);
            if (fire || ill) void'(q.pop_front());
            if (pushed) q.push_back({in_opcode, in_a, in_b});
            if (flush) q.delete();
        end
    end

    // Offer one request starting just after a rising edge; return just after the edge that took it.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok = 0;
        in_valid = 1; in_opcode = op; in_a = a; in_b = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        chk("send_accept", 32'(ok), 'h1);
        in_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready_low", 32'(in_ready), 'h0);
        tick(); rst = 0;
        @(negedge clk);
        chk("reset_unit_valid", 32'(unit_valid), 'h0);
        chk("reset_op_a", op_a, 'h0);
        chk("reset_op_tag", 32'(op_tag), 'h0);
        chk("reset_err", 32'(err_illegal), 'h0);
        chk("reset_in_ready", 32'(in_ready), 'h1);
        tick();

        // 1: add with add unit ready
        unit_ready = 4'b0001;
        send(OP_ADD, 32'h3F800000, 32'h40000000);
        @(negedge clk);
        chk("t1_unit_valid", 32'(unit_valid), 'h1);
        chk("t1_op_a", op_a, 32'h3F800000);
        chk("t1_op_b", op_b, 32'h40000000);
        chk("t1_tag", 32'(op_tag), 'h0);
        tick();
        @(negedge clk);
        chk("t1_idle_valid", 32'(unit_valid), 'h0);
        chk("t1_idle_tag_hold", 32'(op_tag), 'h0);
        chk("t1_idle_a_hold", op_a, 32'h3F800000);
        tick();

        // 2: mul stalled, outputs stable
        unit_ready = 4'b0000;
        send(OP_MUL, 32'h40400000, 32'h40800000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(unit_valid), 'h4);
            chk("t2_hold_a", op_a, 32'h40400000);
            chk("t2_hold_tag", 32'(op_tag), 'h1);
        end
        tick(); unit_ready = 4'b0100;
        tick(); unit_ready = 4'b0000;
        @(negedge clk);
        chk("t2_done", 32'(unit_valid), 'h0);
        tick();

        // 3: fill FIFO with units stalled, third request retried
        send(OP_ADD, 32'h1, 32'h2);
        send(OP_SUB, 32'h3, 32'h4);
        @(negedge clk);
        chk("t3_full", 32'(in_ready), 'h0);
        tick();
        fork
            send(OP_MUL, 32'h5, 32'h6);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t3_stalled", 32'(in_ready), 'h0);
                end
                tick(); unit_ready = 4'b1111;
            end
        join
        repeat (3) tick();

        // 4: illegal opcode between sub and div
        send(OP_SUB, 32'h40A00000, 32'h3F800000);
        @(negedge clk);
        chk("t4_sub_valid", 32'(unit_valid), 'h2);
        chk("t4_sub_tag", 32'(op_tag), 'h5);
        tick();
        send(3'b101, 32'h0, 32'h0);
        send(OP_DIV, 32'h41000000, 32'h40000000);
        @(negedge clk);
        chk("t4_err_pulse", 32'(err_illegal), 'h1);
        chk("t4_div_valid", 32'(unit_valid), 'h8);
        chk("t4_div_tag", 32'(op_tag), 'h6);
        tick();
        @(negedge clk);
        chk("t4_err_single", 32'(err_illegal), 'h0);
        tick();

        // 5: 18 back-to-back issues, tag wraps
        for (int i = 0; i < 18; i++) send(OP_ADD, 32'(i), 32'(i + 1));
        @(negedge clk);
        chk("t5_last_tag", 32'(op_tag), 'h8);
        tick();
        @(negedge clk);
        chk("t5_idle_tag", 32'(op_tag), 'h8);
        tick();

        // 6: flush while div presented and FIFO full; flush-cycle handshake counts
        unit_ready = 4'b0000;
        send(OP_DIV, 32'h41000000, 32'h40000000);
        send(OP_MUL, 32'h3F800000, 32'h3F800000);
        @(negedge clk);
        chk("t6_div_valid", 32'(unit_valid), 'h8);
        chk("t6_div_tag", 32'(op_tag), 'h9);
        tick();
        flush = 1; unit_ready = 4'b1000; in_valid = 1; in_opcode = OP_ADD;
        tick();
        flush = 0; unit_ready = 4'b0000; in_valid = 0;
        @(negedge clk);
        chk("t6_flush_valid", 32'(unit_valid), 'h0);
        chk("t6_flush_ready", 32'(in_ready), 'h1);
        chk("t6_flush_tag_hold", 32'(op_tag), 'h9);
        tick(); unit_ready = 4'b1111;
        send(OP_ADD, 32'h3F800000, 32'h3F800000);
        @(negedge clk);
        chk("t6_tag_after_flush", 32'(op_tag), 'hA);
        tick(); unit_ready = 4'b0000;
        send(OP_SUB, 32'h7, 32'h8);
        flush = 1; in_valid = 1; in_opcode = OP_MUL;
        tick();
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("t6_push_dropped", 32'(unit_valid), 'h0);
        tick();
        @(negedge clk);
        chk("t6_still_idle", 32'(unit_valid), 'h0);
        tick();

        // Reset in the middle of a presentation
        send(OP_MUL, 32'h9, 32'hA);
        rst = 1;
        @(negedge clk);
        chk("t7_rst_ready", 32'(in_ready), 'h0);
        tick(); rst = 0;
        @(negedge clk);
        chk("t7_valid", 32'(unit_valid), 'h0);
        chk("t7_op_a", op_a, 'h0);
        chk("t7_tag", 32'(op_tag), 'h0);
        tick(); unit_ready = 4'b1111;
        send(OP_DIV, 32'hB, 32'hC);
        @(negedge clk);
        chk("t7_div_tag", 32'(op_tag), 'h0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
